// File: rtl/matriz_escalar_pipe.sv
// Matrix-by-scalar multiplier: LANES elements per beat, with wrap, unsigned
// saturate or signed saturate reduction and a sticky overflow flag.
module matriz_escalar_pipe #(
    parameter int DATA_W = 8,
    parameter int DIM    = 5,
    parameter int LANES  = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [DATA_W-1:0]            data_escalar,
    input  logic [DIM*DIM*DATA_W-1:0]    matriz_a,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [DIM*DIM*DATA_W-1:0]    matriz_resultante
);

    localparam int ELEMS  = DIM * DIM;
    localparam int BEATS  = (ELEMS + LANES - 1) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state_q;
    logic [BEAT_W-1:0]            beat_q;
    logic [DATA_W-1:0]            esc_q;
    logic [ELEMS*DATA_W-1:0]      mat_q;
    logic [1:0]                   mode_q;

    logic [LANES-1:0]             lane_en;
    logic [LANES-1:0]             lane_ovf;
    logic [DATA_W-1:0]            lane_val [LANES];
    int                           lane_idx [LANES];

    logic [DATA_W-1:0]            a_elem;
    logic [2*DATA_W-1:0]          prod_u;
    logic [2*DATA_W-1:0]          prod_s;
    int                           idx;

    always_comb begin
        lane_en  = '0;
        lane_ovf = '0;
        lane_val = '{default: '0};
        lane_idx = '{default: 0};
        a_elem   = '0;
        prod_u   = '0;
        prod_s   = '0;
        idx      = 0;
        for (int l = 0; l < LANES; l++) begin
            idx         = int'(beat_q) * LANES + l;
            lane_en[l]  = (idx < ELEMS);
            lane_idx[l] = lane_en[l] ? idx : 0;
            a_elem      = mat_q[lane_idx[l]*DATA_W +: DATA_W];
            prod_u      = {{DATA_W{1'b0}}, a_elem} * {{DATA_W{1'b0}}, esc_q};
            // Sign-extended operands: low 2*DATA_W bits of the product are exact.
            prod_s      = {{DATA_W{a_elem[DATA_W-1]}}, a_elem}
                        * {{DATA_W{esc_q[DATA_W-1]}}, esc_q};
            case (mode_q)
                2'd1: begin
                    lane_ovf[l] = |prod_u[2*DATA_W-1:DATA_W];
                    lane_val[l] = lane_ovf[l] ? {DATA_W{1'b1}} : prod_u[DATA_W-1:0];
                end
                2'd2: begin
                    lane_ovf[l] = (prod_s[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){1'b0}})
                               && (prod_s[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){1'b1}});
                    if (!lane_ovf[l])
                        lane_val[l] = prod_s[DATA_W-1:0];
                    else if (prod_s[2*DATA_W-1])
                        lane_val[l] = {1'b1, {(DATA_W-1){1'b0}}};
                    else
                        lane_val[l] = {1'b0, {(DATA_W-1){1'b1}}};
                end
                default: begin
                    lane_ovf[l] = |prod_u[2*DATA_W-1:DATA_W];
                    lane_val[l] = prod_u[DATA_W-1:0];
                end
            endcase
        end
    end

    // busy/done are registered from the state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            beat_q            <= '0;
            esc_q             <= '0;
            mat_q             <= '0;
            mode_q            <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            overflow          <= 1'b0;
            matriz_resultante <= '0;
        end else begin
            busy <= (state_q != IDLE);
            done <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        esc_q             <= data_escalar;
                        mat_q             <= matriz_a;
                        mode_q            <= mode;
                        matriz_resultante <= '0;
                        overflow          <= 1'b0;
                        beat_q            <= '0;
                        state_q           <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_en[l])
                            matriz_resultante[lane_idx[l]*DATA_W +: DATA_W] <= lane_val[l];
                    end
                    overflow <= overflow | (|(lane_ovf & lane_en));
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        beat_q  <= '0;
                        state_q <= DONE;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/matriz_escalar_pipe.md
MATRIZ_ESCALAR_PIPE -- requirements
Module: matriz_escalar_pipe

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 8: element and scalar width in bits.
- DIM, 5: matrix dimension; ELEMS = DIM*DIM.
- LANES, 5: elements computed per cycle, range 1..ELEMS; BEATS = ceil(ELEMS/LANES).
REQ-002 The design SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk, in, 1: clock, all logic on rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: operation request.
- mode, in, 2: arithmetic mode.
- data_escalar, in, DATA_W: scalar operand.
- matriz_a, in, ELEMS*DATA_W: element i at bits [i*DATA_W +: DATA_W].
- busy, out, 1: operation in progress.
- done, out, 1: one-cycle completion pulse.
- overflow, out, 1: sticky per operation, saturation/wrap occurred.
- matriz_resultante, out, ELEMS*DATA_W: same element packing as matriz_a.

Function
REQ-004 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-005 In IDLE with start=1 at an edge, the block SHALL:
- capture data_escalar, matriz_a and mode into internal registers;
- clear matriz_resultante and overflow to 0;
- set beat index to 0 and enter RUN.
REQ-006 start SHALL be ignored in RUN and DONE; input changes after capture SHALL NOT affect the operation.
REQ-007 Each RUN cycle SHALL write elements beat*LANES .. beat*LANES+LANES-1 of matriz_resultante; lanes with index >= ELEMS SHALL be ignored (partial last beat).
REQ-008 After beat BEATS-1 the FSM SHALL enter DONE; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-009 Timing: busy=1 in RUN and DONE, 0 in IDLE; done=1 only in DONE. For start accepted at edge 0, done SHALL be high in the cycle after edge BEATS+1.
REQ-010 matriz_resultante and overflow SHALL hold their values in IDLE until the next accepted start.
REQ-011 Product SHALL be computed at full 2*DATA_W precision, then reduced by mode:
- 0: unsigned; low DATA_W bits (wrap); overflow if product >= 2^DATA_W.
- 1: unsigned saturate to 2^DATA_W-1; overflow if clipped.
- 2: signed two's complement, saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; overflow if clipped.
- 3: reserved, SHALL behave as mode 0.
REQ-012 overflow SHALL be the OR over all elements of the operation and SHALL remain set until the next accepted start or reset.

Reset
REQ-013 With reset=1 at an edge, the block SHALL force state IDLE, busy=0, done=0, overflow=0, matriz_resultante=0 and beat index 0; reset SHALL take priority over start.
REQ-014 Reset in RUN or DONE SHALL abort the operation with no done pulse; the next start after reset deasserts SHALL run normally.

Verification
REQ-015 Mode 0, scalar 3, all elements 100 -> every element 0x2C, overflow=1, done at cycle 6 (DIM=5, LANES=5), busy high cycles 1-6.
REQ-016 Mode 1, same stimulus -> every element 0xFF, overflow=1. Mode 1, scalar 2, elements 0..24 -> element i = 2i, overflow=0.
REQ-017 Mode 2, scalar 0xFE (-2): element 0x50 -> 0x80 with overflow=1; element 0x10 -> 0xE0; element 0xC0 (-64) -> 0x7F saturated.
REQ-018 LANES=2 (BEATS=13), mode 0, scalar 1, elements i -> result equals input, done at cycle 14, no write beyond element 24.
REQ-019 start re-asserted during RUN and DONE -> ignored, single done pulse; changing matriz_a mid-RUN -> result reflects captured values.
REQ-020 reset at cycle 3 of RUN -> next cycle busy=0, done=0, result all 0, overflow=0; then a start with scalar 0 -> all 0, overflow=0, done at cycle 6.
